encoder32to5_rr: RTL and testbench
==================================

Name: encoder32to5_rr

Overview:
- Reverse-direction companion to the 5-to-32 select decoders.
- Collects request strobes on 32 lines into a sticky pending vector and emits one 5-bit index per transfer on a registered valid/ready output.
- Requests are serviced in round-robin order, so no line starves.
- Used wherever many one-hot or multi-hot sources (interrupt lines, register write-back requests) must be funnelled into a binary select bus.

Parameters:
- N, 32, number of request lines.
- IDX_W, 5, index width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable (positive logic). When 0, req is ignored; draining continues.
- req  input  N  request strobes. A 1 sets the matching pending bit.
- flush  input  1  synchronous clear of all state.
- idx_out  output  IDX_W  binary index of the granted line.
- valid_out  output  1  idx_out holds an unconsumed grant.
- ready_in  input  1  consumer accepts idx_out when valid_out & ready_in.
- pending  output  N  current sticky request vector.
- busy  output  1  registered; (|pending) | valid_out.

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, idx_out=0, valid_out=0, rotation pointer ptr=0, busy=0. All outputs are registered.
- Capture: on each edge, pending <= (pending & ~clr_mask) | (en ? req : 0).
  - Set wins over clear for the same bit in the same cycle.
  - Repeated requests on an already-pending bit merge; there is no counting.
- Load condition: load = ~valid_out | ready_in.
- Selection is combinational from the pending register only; same-cycle req is not visible to it. sel = first set bit of pending scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- On an edge where load=1 and pending≠0:
  - idx_out <= sel.
  - valid_out <= 1.
  - clr_mask = one-hot(sel).
  - ptr <= (sel+1) mod N; wraps from 31 to 0.
- On an edge where load=1 and pending=0: valid_out <= 0. idx_out and ptr hold.
- On an edge where load=0 (valid_out & ~ready_in): idx_out, valid_out and ptr hold. pending still accumulates new requests.
- Handshake:
  - A transfer occurs on an edge where valid_out & ready_in.
  - idx_out and valid_out are stable while valid_out=1 and ready_in=0.
  - Back-to-back grants are issued every cycle while ready_in=1 and pending≠0.
- Latency:
  - req at edge t sets the pending bit at t.
  - With the output idle, valid_out=1 with that index after edge t+1.
  - Throughput is 1 grant/cycle.
- flush=1 (synchronous, highest priority after reset): pending=0, valid_out=0, idx_out=0, ptr=0. req in the same cycle is discarded.
- Boundary cases:
  - All 32 bits pending with ready_in=1: grants 0..31 in order over 32 cycles, then valid_out drops.
  - Grant of the selected bit plus re-request of the same bit in the same cycle: the bit stays pending and is granted again after one full rotation (or immediately, if it is the only pending bit).
  - ready_in is a don't-care while valid_out=0.
  - rst_n asserted mid-transfer: the grant is lost, there is no partial state, and outputs go to their reset values immediately.
- No combinational path from req to any output. The only input-to-output-affecting combinational paths are ready_in into the load enable and flush.
- busy is a registered view of pending and valid_out; its next value is computed from the next-state values of pending and valid_out.

Test Plan:
- Reset/idle: hold rst_n=0, then release with req=0 → idx_out=0, valid_out=0, pending=0, busy=0 for 10 cycles.
- Single request: en=1, req=32'h0000_0400 for one cycle with ready_in=1 → valid_out=1, idx_out=10 one edge later; next edge valid_out=0, pending=0.
- Round-robin wrap: preload req=32'h8000_0003 in one cycle with ready_in=1 → grants 0, 1, 31 on consecutive cycles. Then pulse req bit 0 → grant 0, with ptr having wrapped to 0 after the grant of 31.
- Backpressure: req=32'h0000_0030 with ready_in=0 → idx_out=4, valid_out=1, held stable for 5 cycles while req bit 6 also arrives (pending shows bits 5 and 6). Raise ready_in → grants 4, 5, 6 on consecutive cycles.
- Set-over-clear and enable: with bit 3 the only pending bit, pulse req bit 3 on the edge where 3 is granted → index 3 granted twice, back-to-back. With en=0, req=all-ones → pending unchanged.
- Flush and async reset: with 8 bits pending and valid_out=1, assert flush for one cycle → everything 0 on the next edge. Reload, then drop rst_n mid-cycle → outputs 0 before the next clk edge.

Source files
------------

// File: rtl/encoder32to5_rr.sv
// -----------------------------------------------------------------------------
// encoder32to5_rr
//   Funnels N request strobes into a binary index stream. Incoming strobes are
//   merged into a sticky pending vector, and one index per transfer is
//   presented on a registered valid/ready output. Pending lines are serviced in
//   round-robin order starting just after the most recently granted line.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         capture enable; when low, req is ignored but draining continues
//   req        request strobes, one bit per line, merged into pending
//   flush      synchronous clear of all state; same-cycle req is discarded
//   idx_out    binary index of the granted line (registered)
//   valid_out  idx_out holds an unconsumed grant (registered)
//   ready_in   consumer accepts idx_out on an edge where valid_out is high
//   pending    current sticky request vector (registered)
//   busy       registered (|pending) | valid_out
// -----------------------------------------------------------------------------
module encoder32to5_rr #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic             flush,
    output logic [IDX_W-1:0] idx_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [N-1:0]     pending,
    output logic             busy
);

    logic [N-1:0]     r_pending;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;

    logic [IDX_W-1:0] w_sel;
    logic             w_found;
    int               w_pos;
    logic             w_load;
    logic             w_grant;
    logic [N-1:0]     w_clr_mask;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [N-1:0]     w_pending_nxt;
    logic             w_valid_nxt;

    // Rotating priority scan: first pending line at or after r_ptr, wrapping
    // past N-1 back to 0. Only the registered pending vector is scanned, so a
    // same-cycle req never reaches the outputs combinationally.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned, which would infer a latch.
        w_sel   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(r_ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!w_found && r_pending[IDX_W'(w_pos)]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(w_pos);
            end
        end
    end

    // The output register may take a new grant when it is empty or its current
    // grant is being consumed on this edge.
    always_comb begin
        w_load      = ~r_valid | ready_in;
        w_grant     = w_load & w_found;
        w_clr_mask  = '0;
        if (w_grant) begin
            w_clr_mask[w_sel] = 1'b1;
        end
        w_ptr_nxt     = (w_sel == IDX_W'(N - 1)) ? '0 : w_sel + 1'b1;
        // Set is OR-ed in after the clear, so a re-request of the bit being
        // granted keeps it pending.
        w_pending_nxt = (r_pending & ~w_clr_mask) | (en ? req : '0);
        w_valid_nxt   = w_load ? w_found : r_valid;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
        end else if (flush) begin
            r_pending <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_valid   <= w_valid_nxt;
            if (w_grant) begin
                r_idx <= w_sel;
                r_ptr <= w_ptr_nxt;
            end
            // busy tracks the post-edge state, so it is derived from the
            // next-state values rather than the current registers.
            r_busy <= (|w_pending_nxt) | w_valid_nxt;
        end
    end

    assign idx_out   = r_idx;
    assign valid_out = r_valid;
    assign pending   = r_pending;
    assign busy      = r_busy;

endmodule

// File: tb/tb_encoder32to5_rr.sv
// -----------------------------------------------------------------------------
// tb_encoder32to5_rr
//   Directed bench for encoder32to5_rr. A behavioural model tracks the pending
//   set, the round-robin start point and the output slot; a compare process
//   checks every DUT output against it on each falling edge. Hand-computed
//   literal checks in the stimulus pin the model to the intended behaviour.
// -----------------------------------------------------------------------------
module tb_encoder32to5_rr;

    localparam int N     = 32;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req;
    logic             flush;
    logic [IDX_W-1:0] idx_out;
    logic             valid_out;
    logic             ready_in;
    logic [N-1:0]     pending;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    encoder32to5_rr #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .flush     (flush),
        .idx_out   (idx_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .pending   (pending),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_pending;
    logic         m_valid;
    int           m_idx;
    int           m_ptr;
    logic         m_busy;

    // Line to grant from set p when the rotation starts at 'from'; -1 if empty.
    function automatic int pick(input logic [N-1:0] p, input int from);
        for (int k = 0; k < N; k++) begin
            if (p[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    int           m_sel;
    logic         m_take;
    logic [N-1:0] m_next_pending;
    logic         m_next_valid;

    always_comb begin
        m_sel          = pick(m_pending, m_ptr);
        m_take         = (!m_valid || ready_in) && (m_sel >= 0);
        m_next_pending = m_pending;
        if (m_take) m_next_pending[m_sel] = 1'b0;
        if (en) m_next_pending = m_next_pending | req;
        m_next_valid   = (!m_valid || ready_in) ? (m_pending != '0) : m_valid;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            m_pending <= '0;
            m_valid   <= 1'b0;
            m_idx     <= 0;
            m_ptr     <= 0;
            m_busy    <= 1'b0;
        end else begin
            m_pending <= m_next_pending;
            m_valid   <= m_next_valid;
            if (m_take) begin
                m_idx <= m_sel;
                m_ptr <= (m_sel + 1) % N;
            end
            m_busy <= (m_next_pending != '0) || m_next_valid;
        end
    end

    always @(negedge clk) begin
        check("model_idx_out", 32'(idx_out), 32'(m_idx));
        check("model_valid_out", 32'(valid_out), 32'(m_valid));
        check("model_pending", pending, m_pending);
        check("model_busy", 32'(busy), 32'(m_busy));
    end

    // ---------------- stimulus ----------------
    // Applies one set of inputs across the next rising edge; returns 1 time
    // unit after that edge, where outputs are settled and can be sampled.
    task automatic cyc(input logic c_en, input logic [N-1:0] c_req,
                       input logic c_ready, input logic c_flush);
        en       = c_en;
        req      = c_req;
        ready_in = c_ready;
        flush    = c_flush;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = '0;
        flush    = 1'b0;
        ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid_out), 32'd0);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, '0, 1'b0, 1'b0);
            check("idle_state", {idx_out, valid_out, busy, (pending != '0)}, 32'd0);
        end

        // All lines pending: grants 0..31 in order, then valid drops.
        cyc(1'b1, '1, 1'b1, 1'b0);
        check("all_pending", pending, 32'hFFFF_FFFF);
        check("all_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            check("all_grant_idx", 32'(idx_out), 32'(i));
        end
        check("all_drained", pending, 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("all_valid_drop", 32'(valid_out), 32'd0);

        // Single request: index 10 one edge after capture.
        cyc(1'b1, 32'h0000_0400, 1'b1, 1'b0);
        check("single_pending", pending, 32'h0000_0400);
        check("single_not_yet", 32'(valid_out), 32'd0);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("single_idx", 32'(idx_out), 32'd10);
        check("single_valid", 32'(valid_out), 32'd1);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("single_done", {31'd0, valid_out}, 32'd0);
        check("single_pending_clr", pending, 32'd0);

        // Round-robin wrap, from a rotation restarted at 0 by flush.
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 32'h8000_0003, 1'b1, 1'b0);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("rr_grant0", 32'(idx_out), 32'd0);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("rr_grant1", 32'(idx_out), 32'd1);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("rr_grant31", 32'(idx_out), 32'd31);
        cyc(1'b1, 32'h0000_0001, 1'b1, 1'b0);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("rr_wrap_idx", 32'(idx_out), 32'd0);
        check("rr_wrap_valid", 32'(valid_out), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: grant 4 held while bit 6 arrives; rotation now at 1.
        cyc(1'b1, 32'h0000_0030, 1'b0, 1'b0);
        cyc(1'b1, '0, 1'b0, 1'b0);
        check("bp_first_idx", 32'(idx_out), 32'd4);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, (i == 0) ? 32'h0000_0040 : 32'h0, 1'b0, 1'b0);
            check("bp_hold_idx", 32'(idx_out), 32'd4);
            check("bp_hold_valid", 32'(valid_out), 32'd1);
            check("bp_pending", pending, 32'h0000_0060);
        end
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("bp_grant5", 32'(idx_out), 32'd5);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("bp_grant6", 32'(idx_out), 32'd6);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("bp_drained", 32'(valid_out), 32'd0);

        // Set over clear: bit 3 re-requested on the edge it is granted.
        cyc(1'b1, 32'h0000_0008, 1'b1, 1'b0);
        cyc(1'b1, 32'h0000_0008, 1'b1, 1'b0);
        check("soc_first_idx", 32'(idx_out), 32'd3);
        check("soc_still_pending", pending, 32'h0000_0008);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("soc_second_idx", 32'(idx_out), 32'd3);
        check("soc_second_valid", 32'(valid_out), 32'd1);
        check("soc_cleared", pending, 32'd0);

        // Enable low: req ignored while the output is stalled.
        cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        cyc(1'b0, '1, 1'b0, 1'b0);
        check("en_low_pending", pending, 32'h0000_0100);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        check("en_low_idle", 32'(busy), 32'd0);

        // Flush with 8 lines pending and a grant outstanding; same-cycle req lost.
        cyc(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        check("pre_flush_pending", pending, 32'h0000_01FE);
        check("pre_flush_valid", 32'(valid_out), 32'd1);
        cyc(1'b1, '1, 1'b0, 1'b1);
        check("flush_state", {idx_out, valid_out, busy}, 32'd0);
        check("flush_pending", pending, 32'd0);

        // Reload, then asynchronous reset in the middle of a cycle.
        cyc(1'b1, 32'h0003_0000, 1'b1, 1'b0);
        cyc(1'b1, '0, 1'b1, 1'b0);
        check("reload_idx", 32'(idx_out), 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", {idx_out, valid_out, busy}, 32'd0);
        check("async_rst_pending", pending, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
